flag_cond_ctrl: RTL and testbench
=================================

// Module: flag_cond_ctrl
// PURPOSE
//   Owns the 4-bit NZVC condition-flag register and schedules B.cond resolution against it.
//   - Tracks flag-setting instructions in flight between issue (leaving decode) and commit (EX writeback).
//   - Holds a conditional-branch request until no flag write is pending.
//   - Evaluates the condition code and returns taken/not-taken via a valid/done handshake.
// PARAMETERS
//   MAX_PEND     3        maximum in-flight flag writers tracked (>=1); CW = $clog2(MAX_PEND+1)
//   RESET_FLAGS  4'b0000  flags_q value while reset is active
// PORTS
//   clk            in   1    system clock, rising edge
//   reset          in   1    asynchronous, active-low (0 = reset)
//   fs_issue       in   1    pulse: flag-setting instruction issued
//   fs_commit      in   1    pulse: flag-setting instruction writes flags this cycle
//   negative       in   1    N from ALU, valid with fs_commit
//   zero           in   1    Z from ALU, valid with fs_commit
//   overflow       in   1    V from ALU, valid with fs_commit
//   carry_out      in   1    C from ALU, valid with fs_commit
//   br_valid       in   1    branch request; held with br_cond stable until br_done
//   br_cond        in   4    ARM condition code
//   br_done        out  1    one-cycle pulse: resolution valid
//   br_taken       out  1    condition result, valid only while br_done=1
//   flags_q        out  4    [0]=N [1]=Z [2]=V [3]=C
//   pend_cnt       out  CW   in-flight flag writers
//   fs_full        out  1    pend_cnt == MAX_PEND; upstream must not issue
//   err_underflow  out  1    sticky: commit seen with pend_cnt==0 and no same-cycle issue
// BEHAVIOUR
//   Reset: flags_q=RESET_FLAGS; pend_cnt=0; br_done=br_taken=0; err_underflow=0; FSM=IDLE.
//   - Reset mid-request aborts the request; no br_done is produced.
//   Flags: on fs_commit, flags_q <= {carry_out,overflow,zero,negative} at the next edge; otherwise hold.
//   Counter: issue only -> +1; commit only -> -1; both -> unchanged.
//   - Issue while full: ignored; count saturates at MAX_PEND.
//   - Commit at 0 without same-cycle issue: count stays 0, flags still written, err_underflow <= 1.
//   Conditions: 0 EQ Z | 1 NE !Z | 2 HS C | 3 LO !C | 4 MI N | 5 PL !N | 6 VS V | 7 VC !V
//   - 8 HI C&!Z | 9 LS !C|Z | A GE N==V | B LT N!=V | C GT !Z&(N==V) | D LE Z|(N!=V) | E,F AL 1
//   FSM:
//   - IDLE: br_valid & pend_cnt==0 & !fs_commit -> evaluate flags_q, register br_taken -> DONE.
//     br_valid & (pend_cnt!=0 | fs_commit) -> WAIT.
//   - WAIT: !br_valid -> IDLE (flush; no br_done).
//     fs_commit with next count 0 -> resolve per macro below. Otherwise stay.
//   - RESOLVE: evaluate flags_q (now holds committed flags) -> DONE.
//   - DONE: br_done=1 for exactly one cycle; br_valid ignored; -> IDLE.
//     Requester drops br_valid on the edge that samples br_done.
//   Latency: no hazard -> br_done one cycle after br_valid first sampled.
//   Counter and flag updates continue in every FSM state.
// CONFIGURATION
//   FLAG_BYPASS_EN defined:
//   - WAIT resolves on the commit cycle using the incoming ALU flags (not flags_q) -> DONE.
//   - br_done appears one cycle after the final commit.
//   FLAG_BYPASS_EN undefined:
//   - WAIT -> RESOLVE on the final commit; br_done appears two cycles after it.
//   - RESOLVE state and its encoding are absent when the macro is defined.
// TESTING
//   1 Reset low -> flags_q=0000, pend_cnt=0, br_done=0; release, br_valid cond=E -> br_done, br_taken=1 next cycle.
//   2 Commit N=0,Z=1,V=0,C=0; then br_valid cond=0 (EQ) -> taken=1; cond=1 (NE) -> taken=0; cond=A (GE) -> taken=1.
//   3 Issue x2; br_valid cond=C (GT) -> no br_done; commit Z=0,N=V=1; commit Z=0,N=V=0
//     -> bypass: br_done 1 cycle after 2nd commit, taken=1; no bypass: 2 cycles.
//   4 Issue x4 with MAX_PEND=3 -> pend_cnt=3, fs_full=1; issue+commit same cycle -> 3; commit x4 -> 0, err_underflow=1.
//   5 Issue; br_valid, then drop in WAIT -> FSM IDLE, no br_done; later commit -> flags updated, pend_cnt=0.
//   6 Issue; br_valid; reset low mid-WAIT -> all outputs at reset values, no br_done after release.

Source files
------------

// File: rtl/flag_cond_ctrl.sv
// NZVC flag register with in-flight flag-writer tracking and B.cond resolution.
// Optional FLAG_BYPASS_EN: resolve a waiting branch on the final commit using the incoming ALU flags.
module flag_cond_ctrl #(
  parameter int         MAX_PEND    = 3,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            fs_issue,
  input  logic                            fs_commit,
  input  logic                            negative,
  input  logic                            zero,
  input  logic                            overflow,
  input  logic                            carry_out,
  input  logic                            br_valid,
  input  logic [3:0]                      br_cond,
  output logic                            br_done,
  output logic                            br_taken,
  output logic [3:0]                      flags_q,
  output logic [$clog2(MAX_PEND+1)-1:0]   pend_cnt,
  output logic                            fs_full,
  output logic                            err_underflow
);

  localparam int            CW       = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PEND);

`ifdef FLAG_BYPASS_EN
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT, RESOLVE, DONE} state_t;
`endif

  state_t        state_q, state_d;
  logic [3:0]    flags_d;
  logic [CW-1:0] pend_q, pend_d;
  logic          err_q, err_d;
  logic          br_done_q, br_done_d;
  logic          br_taken_q, br_taken_d;
  logic [3:0]    alu_flags;

  // f[0]=N f[1]=Z f[2]=V f[3]=C
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c, r;
    n = f[0];
    z = f[1];
    v = f[2];
    c = f[3];
    case (cond)
      4'h0:    r = z;
      4'h1:    r = !z;
      4'h2:    r = c;
      4'h3:    r = !c;
      4'h4:    r = n;
      4'h5:    r = !n;
      4'h6:    r = v;
      4'h7:    r = !v;
      4'h8:    r = c & !z;
      4'h9:    r = !c | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = !z & (n == v);
      4'hD:    r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  assign alu_flags = {carry_out, overflow, zero, negative};

  always_comb begin
    flags_d    = fs_commit ? alu_flags : flags_q;
    pend_d     = pend_q;
    err_d      = err_q;
    state_d    = state_q;
    br_done_d  = 1'b0;
    br_taken_d = 1'b0;

    // Simultaneous issue and commit cancel; issue at full is dropped.
    if (fs_issue && !fs_commit) begin
      if (pend_q != PEND_MAX) pend_d = pend_q + 1'b1;
    end else if (fs_commit && !fs_issue) begin
      if (pend_q == '0) err_d = 1'b1;
      else              pend_d = pend_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (br_valid) begin
          if (pend_q == '0 && !fs_commit) begin
            state_d    = DONE;
            br_done_d  = 1'b1;
            br_taken_d = cond_eval(br_cond, flags_q);
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!br_valid) begin
          state_d = IDLE;
        end else if (fs_commit && pend_d == '0) begin
`ifdef FLAG_BYPASS_EN
          state_d    = DONE;
          br_done_d  = 1'b1;
          br_taken_d = cond_eval(br_cond, alu_flags);
`else
          state_d = RESOLVE;
`endif
        end
      end
`ifndef FLAG_BYPASS_EN
      RESOLVE: begin
        state_d    = DONE;
        br_done_d  = 1'b1;
        br_taken_d = cond_eval(br_cond, flags_q);
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      flags_q    <= RESET_FLAGS;
      pend_q     <= '0;
      err_q      <= 1'b0;
      br_done_q  <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      br_done_q  <= br_done_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign br_done       = br_done_q;
  assign br_taken      = br_taken_q;
  assign pend_cnt      = pend_q;
  assign fs_full       = (pend_q == PEND_MAX);
  assign err_underflow = err_q;

endmodule

// File: tb/tb_flag_cond_ctrl.sv
// Bench for flag_cond_ctrl: condition table plus hazard, saturation, flush and reset sequences.
module tb_flag_cond_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fs_issue = 1'b0, fs_commit = 1'b0;
  logic       negative = 1'b0, zero = 1'b0, overflow = 1'b0, carry_out = 1'b0;
  logic       br_valid = 1'b0;
  logic [3:0] br_cond = 4'h0;
  logic       br_done, br_taken, fs_full, err_underflow;
  logic [3:0] flags_q;
  logic [1:0] pend_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

`ifdef FLAG_BYPASS_EN
  localparam int LAT_WAIT = 1;
`else
  localparam int LAT_WAIT = 2;
`endif

  typedef struct {
    logic       taken;
    int         due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       n, z, v, c;
    logic [3:0] cond;
    logic       taken;
  } vec_t;
  vec_t vecs[$];

  flag_cond_ctrl #(.MAX_PEND(3), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .reset(rst_n),
    .fs_issue(fs_issue), .fs_commit(fs_commit),
    .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out),
    .br_valid(br_valid), .br_cond(br_cond),
    .br_done(br_done), .br_taken(br_taken),
    .flags_q(flags_q), .pend_cnt(pend_cnt), .fs_full(fs_full),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Advance one edge, then score any resolution against the queue.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (br_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done got br_done=1 want 0 cyc=%0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("br_taken", int'(br_taken), int'(e.taken));
        chk("done_cycle", cyc, e.due);
      end
    end else if (sb.size() > 0 && cyc >= sb[0].due) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL done_timeout got br_done=0 want 1 due=%0d cyc=%0d", e.due, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fs_issue = 1'b0; fs_commit = 1'b0; br_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic commit(input logic n, input logic z, input logic v, input logic c);
    negative = n; zero = z; overflow = v; carry_out = c;
    fs_commit = 1'b1;
    tick();
    fs_commit = 1'b0;
  endtask

  // Hazard-free request: resolution expected one cycle after first sample.
  task automatic request(input logic [3:0] cond, input logic exp_taken);
    exp_t e;
    br_valid = 1'b1;
    br_cond = cond;
    e.taken = exp_taken;
    e.due = cyc + 1;
    sb.push_back(e);
    for (int i = 0; i < 4 && sb.size() != 0; i++) tick();
    br_valid = 1'b0;
    tick();
  endtask

  initial begin
    // N Z V C cond taken
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h4, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h9, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'hB, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'hC, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'hD, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'h6, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'h7, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'h8, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'h9, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'hE, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 4'hC, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 4'hD, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 4'hB, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'h8, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'hD, 1'b1});

    // Reset values while reset is held, then an unconditional branch.
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_flags", int'(flags_q), 0);
    chk("rst_pend", int'(pend_cnt), 0);
    chk("rst_done", int'(br_done), 0);
    chk("rst_taken", int'(br_taken), 0);
    chk("rst_err", int'(err_underflow), 0);
    rst_n = 1'b1;
    tick();
    request(4'hE, 1'b1);

    // Condition table against committed flags.
    foreach (vecs[i]) begin
      commit(vecs[i].n, vecs[i].z, vecs[i].v, vecs[i].c);
      chk("flags_after_commit", int'(flags_q),
          int'({vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n}));
      request(vecs[i].cond, vecs[i].taken);
    end

    // Branch held behind two in-flight flag writers.
    do_reset();
    fs_issue = 1'b1;
    repeat (2) tick();
    fs_issue = 1'b0;
    chk("hz_pend2", int'(pend_cnt), 2);
    br_valid = 1'b1;
    br_cond = 4'hC;
    repeat (3) tick();
    commit(1'b1, 1'b0, 1'b1, 1'b0);
    chk("hz_pend1", int'(pend_cnt), 1);
    sb.push_back('{1'b1, cyc + LAT_WAIT});
    commit(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4 && sb.size() != 0; i++) tick();
    br_valid = 1'b0;
    tick();
    chk("hz_pend0", int'(pend_cnt), 0);

    // Saturation, issue+commit cancel, then underflow.
    do_reset();
    fs_issue = 1'b1;
    repeat (4) tick();
    chk("sat_pend", int'(pend_cnt), 3);
    chk("sat_full", int'(fs_full), 1);
    fs_commit = 1'b1;
    tick();
    chk("issue_commit_pend", int'(pend_cnt), 3);
    fs_issue = 1'b0;
    repeat (3) tick();
    chk("drain_pend", int'(pend_cnt), 0);
    chk("drain_full", int'(fs_full), 0);
    chk("no_err_yet", int'(err_underflow), 0);
    tick();
    fs_commit = 1'b0;
    chk("uflow_pend", int'(pend_cnt), 0);
    chk("uflow_err", int'(err_underflow), 1);
    tick();
    chk("uflow_sticky", int'(err_underflow), 1);

    // Request withdrawn while waiting: no resolution, FSM back to IDLE.
    do_reset();
    fs_issue = 1'b1;
    tick();
    fs_issue = 1'b0;
    br_valid = 1'b1;
    br_cond = 4'hE;
    repeat (2) tick();
    br_valid = 1'b0;
    repeat (3) tick();
    commit(1'b1, 1'b0, 1'b1, 1'b1);
    chk("flush_flags", int'(flags_q), 4'b1101);
    chk("flush_pend", int'(pend_cnt), 0);
    request(4'h4, 1'b1);

    // Reset asserted mid-wait aborts the request.
    do_reset();
    commit(1'b1, 1'b1, 1'b1, 1'b1);
    fs_issue = 1'b1;
    tick();
    fs_issue = 1'b0;
    br_valid = 1'b1;
    br_cond = 4'hE;
    repeat (2) tick();
    rst_n = 1'b0;
    br_valid = 1'b0;
    #1;
    chk("arst_flags", int'(flags_q), 0);
    chk("arst_pend", int'(pend_cnt), 0);
    chk("arst_err", int'(err_underflow), 0);
    chk("arst_done", int'(br_done), 0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_pend", int'(pend_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
